// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the 6502 program-counter stage.
package pc_unit_pkg;

    // Two-state sequencer: normal operation, or the extra PCH fix-up cycle
    typedef enum logic {
        IDLE   = 1'b0,
        FIX_HI = 1'b1
    } pc_state_e;

    // Direction in which PCH moves during the fix-up cycle
    typedef enum logic {
        FIX_INC = 1'b0,
        FIX_DEC = 1'b1
    } pc_fix_e;

    // Reset-vector fetch address
    localparam logic [15:0] PC_RESET_DEFAULT = 16'hFFFC;

    // PCH adjusted by one page in the given direction, modulo 256
    function automatic logic [7:0] pc_fix_apply(input logic [7:0] pch, input pc_fix_e dir);
        return (dir == FIX_DEC) ? pch - 8'd1 : pch + 8'd1;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Command/status bundle between the sequencer (master) and the PC stage (slave).
interface pc_unit_if;
    logic        inc;
    logic        load_lo;
    logic        load_hi;
    logic [7:0]  adl_in;
    logic [7:0]  adh_in;
    logic        branch_take;
    logic [7:0]  offset;
    logic [15:0] pc_out;
    logic        busy;
    logic        page_cross;

    modport master (
        output inc, load_lo, load_hi, adl_in, adh_in, branch_take, offset,
        input  pc_out, busy, page_cross
    );

    modport slave (
        input  inc, load_lo, load_hi, adl_in, adh_in, branch_take, offset,
        output pc_out, busy, page_cross
    );
endinterface

// File: rtl/pc_branch_adder.sv
// Low-byte branch add. Only PCL is summed here; a mismatch between the
// carry and the sign of the displacement means PCH must move next cycle.
module pc_branch_adder
    import pc_unit_pkg::*;
(
    input  logic [7:0] pcl,
    input  logic [7:0] offset,
    output logic [7:0] new_pcl,
    output logic       need_fix,
    output pc_fix_e    fix_dir
);

    logic [8:0] sum;

    // 9-bit sum: forward branch with carry or backward branch without carry
    // leaves the page
    always_comb begin
        sum      = {1'b0, pcl} + {1'b0, offset};
        new_pcl  = sum[7:0];
        need_fix = offset[7] ^ sum[8];
        fix_dir  = offset[7] ? FIX_DEC : FIX_INC;
    end

endmodule

// File: rtl/pc_reg8.sv
// 8-bit register with load enable; reset value supplied as a port so the
// byte halves of a wider constant can be fed in.
module pc_reg8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rst_val,
    input  logic       ld,
    input  logic [7:0] d,
    output logic [7:0] q
);

    // Hold unless loaded; async reset forces the supplied reset value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= rst_val;
        else if (ld) q <= d;
    end

endmodule

// File: rtl/pc_unit.sv
// 6502 program counter: PCL/PCH byte registers, increment, absolute load and
// relative branch with the extra PCH fix-up cycle on a page crossing.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = PC_RESET_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);

    pc_state_e  state;
    pc_fix_e    fix;

    logic [7:0] pcl, pch;
    logic [7:0] pcl_d, pch_d;
    logic       pcl_ld, pch_ld;
    logic [15:0] pc_inc;

    logic [7:0] br_pcl;
    logic       br_need_fix;
    pc_fix_e    br_fix_dir;

    logic       cmd_load;

    pc_branch_adder u_br (
        .pcl      (pcl),
        .offset   (bus.offset),
        .new_pcl  (br_pcl),
        .need_fix (br_need_fix),
        .fix_dir  (br_fix_dir)
    );

    pc_reg8 u_pcl (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RESET_PC[7:0]),
        .ld      (pcl_ld),
        .d       (pcl_d),
        .q       (pcl)
    );

    pc_reg8 u_pch (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RESET_PC[15:8]),
        .ld      (pch_ld),
        .d       (pch_d),
        .q       (pch)
    );

    assign cmd_load = bus.load_lo | bus.load_hi;

    // Byte-register update selection: load > branch > inc > hold in IDLE;
    // fix-up cycle only touches PCH
    always_comb begin
        pcl_ld = 1'b0;
        pch_ld = 1'b0;
        pcl_d  = pcl;
        pch_d  = pch;
        pc_inc = {pch, pcl} + 16'd1;
        unique case (state)
            IDLE: begin
                if (cmd_load) begin
                    pcl_ld = bus.load_lo;
                    pch_ld = bus.load_hi;
                    pcl_d  = bus.adl_in;
                    pch_d  = bus.adh_in;
                end else if (bus.branch_take) begin
                    pcl_ld = 1'b1;
                    pcl_d  = br_pcl;
                end else if (bus.inc) begin
                    pcl_ld = 1'b1;
                    pch_ld = 1'b1;
                    pcl_d  = pc_inc[7:0];
                    pch_d  = pc_inc[15:8];
                end
            end
            FIX_HI: begin
                pch_ld = 1'b1;
                pch_d  = pc_fix_apply(pch, fix);
            end
            default: ;
        endcase
    end

    // Sequencer: enter FIX_HI for one cycle when a taken branch leaves the page
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            fix   <= FIX_INC;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!cmd_load && bus.branch_take && br_need_fix) begin
                        state <= FIX_HI;
                        fix   <= br_fix_dir;
                    end
                end
                FIX_HI:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Status is a pure decode of the state flop, so it cannot glitch
    assign bus.busy       = (state == FIX_HI);
    assign bus.page_cross = (state == FIX_HI);
    assign bus.pc_out     = {pch, pcl};

endmodule
